noc_mesh_router: RTL and testbench
==================================

Name: noc_mesh_router

Overview:
- 5-port wormhole router for a 2D mesh NoC, 4x4 maximum (2-bit coordinates).
- Each input port has a small flit FIFO. Head flits are routed with dimension-ordered XY routing.
- Each output port has a round-robin arbiter and is locked to the winning input until the packet's tail flit passes.
- Instantiated once per mesh tile; port 0 connects to the local network interface.

Parameters:
- PORT_N, 5, number of ports (0=LOCAL, 1=NORTH y+1, 2=EAST x+1, 3=SOUTH y-1, 4=WEST x-1).
- FIFO_DEPTH, 4, flits per input FIFO (power of two).
- DATA_W, 32, payload width; flit width is DATA_W+2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- my_xpos  in  2  this router's X coordinate.
- my_ypos  in  2  this router's Y coordinate.
- in_data  in  PORT_N*(DATA_W+2)  per-port flit {type[1:0], payload}; port p occupies slice p.
- in_valid  in  PORT_N  per-port flit valid.
- in_ack  out  PORT_N  per-port "input FIFO not full" (ready to the upstream sender).
- out_data  out  PORT_N*(DATA_W+2)  per-port outgoing flit.
- out_valid  out  PORT_N  per-port outgoing flit valid.
- out_ack  in  PORT_N  per-port "downstream can accept a flit this cycle".

Behaviour:
- Flit type encoding: NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- Head payload: destination x = payload[1:0], destination y = payload[3:2].
- Reset (async, rst=1):
  - all FIFOs emptied, all output locks and arbiter pointers cleared (pointer=0);
  - out_valid=0, out_data=0;
  - in_ack=all ones, since FIFOs are empty.
- Input side:
  - a flit is written at a clk edge when in_valid[p]=1, type!=NONE and the FIFO is not full;
  - a NONE flit or in_valid=0 writes nothing;
  - in_ack[p] = !full, combinational from the FIFO count;
  - a write attempted while full is dropped; the sender must obey in_ack.
  - Simultaneous read and write of one FIFO in the same cycle is legal, including when full; count is unchanged.
- Routing (combinational on the HEAD flit at the FIFO front):
  - dx>my_xpos → EAST; dx<my_xpos → WEST;
  - else dy>my_ypos → NORTH; dy<my_ypos → SOUTH;
  - else LOCAL.
- Each input stores its routed output port in a register when its head wins the arbiter. DATA and TAIL flits follow that stored port.
- Arbitration per output:
  - only unlocked outputs arbitrate, among inputs whose front flit is a HEAD routed to that output;
  - round-robin: search starts at (last grant+1) mod PORT_N;
  - the grant locks the output to that input.
- Transfer:
  - when input p owns output o, its FIFO is non-empty and out_ack[o]=1, the front flit is popped;
  - it is registered into out_data[o] with out_valid[o]=1 at that edge;
  - otherwise out_valid[o]=0 next cycle and out_data[o] holds its last value.
- The head may transfer in the same cycle it wins arbitration.
- The lock is released after the TAIL flit transfers. The freed output may be re-granted at the next edge.
- Latency: a flit written at edge k appears on out_data/out_valid after edge k+1 when uncontended and out_ack=1.
- Minimum throughput: 1 flit per cycle per output.
- Back-pressure: out_ack[o]=0 stalls the owning input with no loss and no duplication. Its FIFO fills and then in_ack drops.
- Multiple inputs may drive different outputs concurrently. U-turns (head routed back to its own arrival port) are not allowed by XY routing.

Test Plan:
- Reset: assert rst mid-packet → out_valid=0 and in_ack=5'b11111 immediately (no clock needed); after release, no stale flits emerge.
- Single packet, my_xpos=1, my_ypos=1, out_ack=all 1:
  - stimulus on port 0: HEAD 0x09, four DATA, TAIL;
  - required: six flits on out_valid[1] (NORTH), identical and in order;
  - first flit appears 2 edges after it is driven;
  - lock then releases.
- Routing sweep at (1,1):
  - dest (2,1) → EAST; (0,3) → WEST; (1,0) → SOUTH; (1,1) → LOCAL;
  - dest (3,3) → EAST first, since x is resolved before y.
- Contention:
  - ports 2 and 4 both send 3-flit packets to LOCAL at the same edge;
  - required: port 2's whole packet first, then port 4's whole packet;
  - no interleaving of flits;
  - arbiter pointer advances past 2.
- Back-pressure: hold out_ack[1]=0 while a 6-flit packet arrives → in_ack[0] falls after 4 flits are buffered; releasing out_ack delivers all 6 in order.
- Concurrency: port 0→EAST and port 3→WEST packets sent simultaneously → both outputs stream one flit per cycle with no stalls.

Source files
------------

// File: rtl/noc_mesh_router.sv
// -----------------------------------------------------------------------------
// noc_mesh_router
//
// Purpose:
//   Five-port wormhole router for one tile of a 2D mesh (up to 4x4, 2-bit
//   coordinates). Each input port buffers flits in a small FIFO. A HEAD flit
//   at the front of a FIFO is routed with XY dimension-ordered routing: X is
//   resolved first, then Y. Each output port has a round-robin arbiter. The
//   winning input holds the output until its TAIL flit has passed.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   my_xpos    this router's X coordinate
//   my_ypos    this router's Y coordinate
//   in_data    per-port flit {type[1:0], payload[DATA_W-1:0]}, port p = slice p
//   in_valid   per-port flit valid
//   in_ack     per-port "input FIFO not full"
//   out_data   per-port registered outgoing flit
//   out_valid  per-port outgoing flit valid
//   out_ack    per-port "downstream accepts a flit this cycle"
//
// Port numbering: 0=LOCAL, 1=NORTH (y+1), 2=EAST (x+1), 3=SOUTH (y-1),
// 4=WEST (x-1).
//
// Handshake:
//   Input side: the sender may present a flit only while in_ack[p]=1. A flit
//   is taken at a rising edge when in_valid[p]=1 and its type is not NONE.
//   Output side: a flit moves from the owning input FIFO to out_data[o] at a
//   rising edge when out_ack[o]=1. out_valid[o] is high for the one cycle after
//   that edge. When out_valid[o] is low, out_data[o] keeps its last value.
// -----------------------------------------------------------------------------
module noc_mesh_router #(
   parameter int PORT_N     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   my_xpos,
   input  logic [1:0]                   my_ypos,
   input  logic [PORT_N*(DATA_W+2)-1:0] in_data,
   input  logic [PORT_N-1:0]            in_valid,
   output logic [PORT_N-1:0]            in_ack,
   output logic [PORT_N*(DATA_W+2)-1:0] out_data,
   output logic [PORT_N-1:0]            out_valid,
   input  logic [PORT_N-1:0]            out_ack
);

   localparam int FW = DATA_W + 2;
   localparam int PW = (PORT_N > 1) ? $clog2(PORT_N) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0]    T_NONE   = 2'b00;
   localparam logic [1:0]    T_HEAD   = 2'b01;
   localparam logic [1:0]    T_TAIL   = 2'b11;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

   localparam logic [PW-1:0] P_LOCAL = PW'(0);
   localparam logic [PW-1:0] P_NORTH = PW'(1);
   localparam logic [PW-1:0] P_EAST  = PW'(2);
   localparam logic [PW-1:0] P_SOUTH = PW'(3);
   localparam logic [PW-1:0] P_WEST  = PW'(4);

   // XY routing on a head's destination field {dy, dx}.
   function automatic logic [PW-1:0] xy_route(input logic [3:0] dst,
                                              input logic [1:0] mx,
                                              input logic [1:0] my);
      logic [1:0] dx;
      logic [1:0] dy;
      dx = dst[1:0];
      dy = dst[3:2];
      if (dx > mx)      return P_EAST;
      else if (dx < mx) return P_WEST;
      else if (dy > my) return P_NORTH;
      else if (dy < my) return P_SOUTH;
      else              return P_LOCAL;
   endfunction

   // ---------------- state ----------------
   logic [FW-1:0]     mem_q      [PORT_N][FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr_q   [PORT_N];
   logic [AW-1:0]     wr_ptr_q   [PORT_N];
   logic [CW-1:0]     cnt_q      [PORT_N];
   logic [PW-1:0]     route_q    [PORT_N];
   logic [PORT_N-1:0] lock_q,  lock_d;
   logic [PW-1:0]     owner_q    [PORT_N];
   logic [PW-1:0]     owner_d    [PORT_N];
   logic [PW-1:0]     ptr_q      [PORT_N];
   logic [PW-1:0]     ptr_d      [PORT_N];
   logic [FW-1:0]     out_data_q [PORT_N];
   logic [PORT_N-1:0] out_valid_q;

   // ---------------- combinational ----------------
   logic [FW-1:0]     front      [PORT_N];
   logic [PW-1:0]     head_route [PORT_N];
   logic [PW-1:0]     cur_route  [PORT_N];
   logic [PORT_N-1:0] nonempty, full, front_head, busy, wr_en, pop;
   logic [PORT_N-1:0] gnt_vld, owned, xfer;
   logic [PW-1:0]     gnt_idx    [PORT_N];
   logic [PW-1:0]     eff_owner  [PORT_N];
   logic [FW-1:0]     xfer_flit  [PORT_N];

   // FIFO status and head routing.
   always_comb begin
      for (int p = 0; p < PORT_N; p++) begin
         front[p]      = mem_q[p][rd_ptr_q[p]];
         nonempty[p]   = (cnt_q[p] != '0);
         full[p]       = (cnt_q[p] == FULL_CNT);
         front_head[p] = nonempty[p] && (front[p][FW-1 -: 2] == T_HEAD);
         head_route[p] = xy_route(front[p][3:0], my_xpos, my_ypos);
      end
   end

   // An input that already holds an output is mid-packet and must not request.
   always_comb begin
      busy = '0;
      for (int p = 0; p < PORT_N; p++) begin
         for (int o = 0; o < PORT_N; o++) begin
            if (lock_q[o] && (owner_q[o] == PW'(p))) busy[p] = 1'b1;
         end
      end
   end

   // Round-robin arbitration on unlocked outputs, starting after the last grant.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      gnt_vld = '0;
      for (int o = 0; o < PORT_N; o++) begin
         gnt_idx[o] = '0;
         if (!lock_q[o]) begin
            for (int k = 1; k <= PORT_N; k++) begin
               idx = PW'((int'(ptr_q[o]) + k) % PORT_N);
               if (!gnt_vld[o] && front_head[idx] && !busy[idx] &&
                   (head_route[idx] == PW'(o))) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = idx;
               end
            end
         end
      end
   end

   // Transfer: a fresh grant counts as ownership, so a head can move in the
   // same cycle it wins.
   always_comb begin
      for (int o = 0; o < PORT_N; o++) begin
         owned[o]     = lock_q[o] | gnt_vld[o];
         eff_owner[o] = lock_q[o] ? owner_q[o] : gnt_idx[o];
         xfer[o]      = owned[o] && nonempty[eff_owner[o]] && out_ack[o];
         xfer_flit[o] = front[eff_owner[o]];
      end
   end

   // Each input pops through the single output it owns or has just won.
   always_comb begin
      for (int p = 0; p < PORT_N; p++) begin
         cur_route[p] = busy[p] ? route_q[p] : head_route[p];
         pop[p]       = xfer[cur_route[p]] && (eff_owner[cur_route[p]] == PW'(p));
         // A concurrent pop frees a slot, so a full FIFO can still take a flit.
         wr_en[p]     = in_valid[p] && (in_data[p*FW+FW-1 -: 2] != T_NONE) &&
                        (!full[p] || pop[p]);
      end
   end

   // Lock, owner and pointer next state. A TAIL release overrides the lock.
   always_comb begin
      lock_d = lock_q;
      for (int o = 0; o < PORT_N; o++) begin
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (gnt_vld[o]) begin
            lock_d[o]  = 1'b1;
            owner_d[o] = gnt_idx[o];
            ptr_d[o]   = gnt_idx[o];
         end
         if (xfer[o] && (xfer_flit[o][FW-1 -: 2] == T_TAIL)) lock_d[o] = 1'b0;
      end
   end

   // ---------------- sequential ----------------
   // FIFO storage needs no reset. Emptiness comes from the counters.
   always_ff @(posedge clk) begin
      for (int p = 0; p < PORT_N; p++) begin
         if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= in_data[p*FW +: FW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PORT_N; p++) begin
            rd_ptr_q[p] <= '0;
            wr_ptr_q[p] <= '0;
            cnt_q[p]    <= '0;
            route_q[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < PORT_N; p++) begin
            if (wr_en[p]) wr_ptr_q[p] <= (wr_ptr_q[p] == LAST_PTR) ? '0 : wr_ptr_q[p] + AW'(1);
            if (pop[p])   rd_ptr_q[p] <= (rd_ptr_q[p] == LAST_PTR) ? '0 : rd_ptr_q[p] + AW'(1);
            case ({wr_en[p], pop[p]})
               2'b10:   cnt_q[p] <= cnt_q[p] + CW'(1);
               2'b01:   cnt_q[p] <= cnt_q[p] - CW'(1);
               default: cnt_q[p] <= cnt_q[p];
            endcase
         end
         for (int o = 0; o < PORT_N; o++) begin
            if (gnt_vld[o]) route_q[gnt_idx[o]] <= PW'(o);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q      <= '0;
         out_valid_q <= '0;
         for (int o = 0; o < PORT_N; o++) begin
            owner_q[o]    <= '0;
            ptr_q[o]      <= '0;
            out_data_q[o] <= '0;
         end
      end else begin
         lock_q      <= lock_d;
         out_valid_q <= xfer;
         for (int o = 0; o < PORT_N; o++) begin
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
            if (xfer[o]) out_data_q[o] <= xfer_flit[o];
         end
      end
   end

   // ---------------- outputs ----------------
   assign in_ack    = ~full;
   assign out_valid = out_valid_q;

   for (genvar g = 0; g < PORT_N; g++) begin : g_out
      assign out_data[g*FW +: FW] = out_data_q[g];
   end

endmodule

// File: tb/tb_noc_mesh_router.sv
// -----------------------------------------------------------------------------
// tb_noc_mesh_router
//
// Purpose:
//   Testbench for noc_mesh_router. A packet-level reference model predicts
//   the registered outputs and the in_ack of every port on each cycle. Directed
//   scenarios pin routing, ordering, latency, back-pressure and reset with
//   literal expectations. A randomized phase runs at random tile coordinates
//   with random gaps, NONE flits and out_ack stalls.
// -----------------------------------------------------------------------------
module tb_noc_mesh_router;

   localparam int N  = 5;
   localparam int D  = 4;
   localparam int DW = 32;
   localparam int FW = DW + 2;

   localparam logic [1:0] H  = 2'b01;
   localparam logic [1:0] DT = 2'b10;
   localparam logic [1:0] TL = 2'b11;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      my_xpos = 2'd0;
   logic [1:0]      my_ypos = 2'd0;
   logic [N*FW-1:0] in_data = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ack;
   logic [N*FW-1:0] out_data;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ack = '1;

   noc_mesh_router #(.PORT_N(N), .FIFO_DEPTH(D), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .my_xpos   (my_xpos),
      .my_ypos   (my_ypos),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- counters and compare helper ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %h expected %h (cycle %0d)", nm, idx, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Each input FIFO is a queue. Each output is held by one input (-1 = free).
   // The model remembers the last granted input for round-robin.
   logic [FW-1:0] mq [N][$];
   int            m_owner [N];
   int            m_last  [N];
   logic [N-1:0]  exp_valid;
   logic [FW-1:0] exp_data [N];

   function automatic int xy(input logic [FW-1:0] f, input logic [1:0] mx, input logic [1:0] my);
      int dx, dy;
      dx = int'(f[1:0]);
      dy = int'(f[3:2]);
      if (dx > int'(mx)) return 2;
      if (dx < int'(mx)) return 4;
      if (dy > int'(my)) return 1;
      if (dy < int'(my)) return 3;
      return 0;
   endfunction

   function automatic bit holds_output(input int i);
      for (int o = 0; o < N; o++) if (m_owner[o] == i) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [FW-1:0] f;
      bit            taken;
      int            i;
      if (rst) begin
         for (int p = 0; p < N; p++) begin
            mq[p].delete();
            m_owner[p]  = -1;
            m_last[p]   = 0;
            exp_data[p] = '0;
         end
         exp_valid = '0;
      end else begin
         // grants from the pre-edge FIFO fronts
         for (int o = 0; o < N; o++) begin
            if (m_owner[o] < 0) begin
               taken = 1'b0;
               for (int k = 1; k <= N; k++) begin
                  i = (m_last[o] + k) % N;
                  if (!taken && mq[i].size() > 0 && mq[i][0][FW-1 -: 2] == H &&
                      xy(mq[i][0], my_xpos, my_ypos) == o && !holds_output(i)) begin
                     m_owner[o] = i;
                     m_last[o]  = i;
                     taken      = 1'b1;
                  end
               end
            end
         end
         // transfers
         for (int o = 0; o < N; o++) begin
            exp_valid[o] = 1'b0;
            if (m_owner[o] >= 0 && mq[m_owner[o]].size() > 0 && out_ack[o]) begin
               f            = mq[m_owner[o]].pop_front();
               exp_valid[o] = 1'b1;
               exp_data[o]  = f;
               if (f[FW-1 -: 2] == TL) m_owner[o] = -1;
            end
         end
         // writes
         for (int p = 0; p < N; p++) begin
            f = in_data[p*FW +: FW];
            if (in_valid[p] && f[FW-1 -: 2] != 2'b00 && mq[p].size() < D) mq[p].push_back(f);
         end
      end
   end

   // ---------------- per-cycle compare and output log ----------------
   logic [FW-1:0] log_d [N][$];
   int            log_c [N][$];

   always @(negedge clk) begin
      if (!rst) begin
         for (int o = 0; o < N; o++) begin
            chk("out_valid", o, FW'(out_valid[o]), FW'(exp_valid[o]));
            chk("out_data", o, out_data[o*FW +: FW], exp_data[o]);
            if (out_valid[o]) begin
               log_d[o].push_back(out_data[o*FW +: FW]);
               log_c[o].push_back(cyc);
            end
         end
         for (int p = 0; p < N; p++) chk("in_ack", p, FW'(in_ack[p]), FW'(mq[p].size() < D));
      end
   end

   // ---------------- driver ----------------
   logic [FW-1:0] send_q [N][$];
   int            gap_pct = 0;
   int            base [N];

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [DW-1:0] pl);
      return {t, pl};
   endfunction

   // One cycle. Inputs change on the falling edge. A sender presents a flit
   // only while in_ack is high.
   task automatic step();
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
         if (rst) begin
            in_valid[p]         = 1'b0;
            in_data[p*FW +: FW] = '0;
         end else if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid[p]         = 1'($urandom_range(1));
            in_data[p*FW +: FW] = {2'b00, DW'($urandom)};
         end else if (send_q[p].size() > 0 && in_ack[p]) begin
            in_data[p*FW +: FW] = send_q[p].pop_front();
            in_valid[p]         = 1'b1;
         end else begin
            in_valid[p]         = 1'b0;
            in_data[p*FW +: FW] = '0;
         end
      end
   endtask

   function automatic bit all_empty();
      for (int p = 0; p < N; p++) if (send_q[p].size() != 0 || mq[p].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (n < budget && !all_empty()) begin
         step();
         n++;
      end
      chk("drain_done", 0, FW'(all_empty()), FW'(1));
      repeat (4) step();
   endtask

   task automatic snap();
      for (int o = 0; o < N; o++) base[o] = log_d[o].size();
   endtask

   function automatic int got_n(input int o);
      return log_d[o].size() - base[o];
   endfunction

   task automatic chk_seq(input string nm, input int o, input logic [FW-1:0] e[$]);
      chk(nm, 100 + o, FW'(got_n(o)), FW'(e.size()));
      for (int i = 0; i < e.size(); i++)
         chk(nm, i, (base[o] + i < log_d[o].size()) ? log_d[o][base[o] + i] : '0, e[i]);
   endtask

   task automatic push_pkt(input int p, input logic [FW-1:0] pk[$]);
      foreach (pk[i]) send_q[p].push_back(pk[i]);
   endtask

   task automatic do_reset(input logic [1:0] x, input logic [1:0] y);
      rst      = 1'b1;
      my_xpos  = x;
      my_ypos  = y;
      out_ack  = '1;
      gap_pct  = 0;
      for (int p = 0; p < N; p++) send_q[p].delete();
      repeat (2) step();
      chk("rst_out_valid", 0, FW'(out_valid), FW'(0));
      chk("rst_in_ack", 0, FW'(in_ack), FW'(5'b11111));
      for (int o = 0; o < N; o++) chk("rst_out_data", o, out_data[o*FW +: FW], '0);
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      logic [FW-1:0] pk[$];
      logic [FW-1:0] pk2[$];
      logic [FW-1:0] pk3[$];
      int            c0;
      int            tot;
      int            rt_dst [5];
      int            rt_src [5];
      int            rt_exp [5];
      int            len;

      // single packet at (1,1), HEAD 0x09 -> NORTH
      do_reset(2'd1, 2'd1);
      snap();
      pk = '{mk(H, 32'h09), mk(DT, 32'h11111111), mk(DT, 32'h22222222),
             mk(DT, 32'h33333333), mk(DT, 32'h44444444), mk(TL, 32'h55555555)};
      push_pkt(0, pk);
      step();
      c0 = cyc;
      drain(100);
      chk_seq("single_north", 1, pk);
      chk("single_latency", 0, FW'((log_c[1].size() > base[1]) ? log_c[1][base[1]] : -1), FW'(c0 + 2));
      chk("single_stray", 0, FW'(got_n(0) + got_n(2) + got_n(3) + got_n(4)), FW'(0));
      // the lock is released: another input can use NORTH afterwards
      snap();
      pk2 = '{mk(H, 32'hABC00009), mk(TL, 32'h66666666)};
      push_pkt(2, pk2);
      drain(100);
      chk_seq("relock_north", 1, pk2);

      // routing sweep at (1,1); payload[3:0] = {dy, dx}
      rt_dst = '{32'h6, 32'hC, 32'h1, 32'h5, 32'hF};
      rt_src = '{0, 0, 0, 2, 0};
      rt_exp = '{2, 4, 3, 0, 2};
      for (int i = 0; i < 5; i++) begin
         snap();
         push_pkt(rt_src[i], '{mk(H, DW'(rt_dst[i])), mk(TL, DW'(32'h700 + i))});
         drain(100);
         chk("route_port", i, FW'(got_n(rt_exp[i])), FW'(2));
         tot = 0;
         for (int o = 0; o < N; o++) tot += got_n(o);
         chk("route_total", i, FW'(tot), FW'(2));
      end

      // contention: ports 2 and 4 to LOCAL at the same edge; port 2 wins first
      do_reset(2'd1, 2'd1);
      snap();
      pk  = '{mk(H, 32'h20000005), mk(DT, 32'h200000D1), mk(TL, 32'h200000E1)};
      pk2 = '{mk(H, 32'h40000005), mk(DT, 32'h400000D1), mk(TL, 32'h400000E1)};
      push_pkt(2, pk);
      push_pkt(4, pk2);
      drain(100);
      pk3 = {pk, pk2};
      chk_seq("contention", 0, pk3);

      // back-pressure on NORTH: four flits buffer, then in_ack[0] drops
      do_reset(2'd1, 2'd1);
      snap();
      out_ack[1] = 1'b0;
      pk = '{mk(H, 32'hB0000009), mk(DT, 32'hB1), mk(DT, 32'hB2),
             mk(DT, 32'hB3), mk(DT, 32'hB4), mk(TL, 32'hB5)};
      push_pkt(0, pk);
      repeat (10) step();
      chk("bp_in_ack", 0, FW'(in_ack[0]), FW'(0));
      chk("bp_left", 0, FW'(send_q[0].size()), FW'(2));
      chk("bp_none_out", 1, FW'(got_n(1)), FW'(0));
      out_ack = '1;
      drain(100);
      chk_seq("bp_release", 1, pk);

      // concurrency: port 0 -> EAST and port 3 -> WEST stream in parallel
      do_reset(2'd1, 2'd1);
      snap();
      pk  = '{mk(H, 32'hC0000006), mk(DT, 32'hC1), mk(DT, 32'hC2), mk(DT, 32'hC3), mk(TL, 32'hC4)};
      pk2 = '{mk(H, 32'hD0000004), mk(DT, 32'hD1), mk(DT, 32'hD2), mk(DT, 32'hD3), mk(TL, 32'hD4)};
      push_pkt(0, pk);
      push_pkt(3, pk2);
      drain(100);
      chk_seq("conc_east", 2, pk);
      chk_seq("conc_west", 4, pk2);
      chk("conc_span_e", 0, FW'((log_c[2].size() >= base[2] + 5) ? log_c[2][base[2] + 4] - log_c[2][base[2]] : -1), FW'(4));
      chk("conc_span_w", 0, FW'((log_c[4].size() >= base[4] + 5) ? log_c[4][base[4] + 4] - log_c[4][base[4]] : -1), FW'(4));
      chk("conc_same_start", 0, FW'((log_c[2].size() > base[2] && log_c[4].size() > base[4]) ?
                                    log_c[2][base[2]] - log_c[4][base[4]] : -1), FW'(0));

      // asynchronous reset mid-packet
      do_reset(2'd1, 2'd1);
      pk = '{mk(H, 32'hE0000009), mk(DT, 32'hE1), mk(DT, 32'hE2),
             mk(DT, 32'hE3), mk(DT, 32'hE4), mk(TL, 32'hE5)};
      push_pkt(0, pk);
      repeat (3) step();
      chk("mid_pkt_valid", 1, FW'(out_valid[1]), FW'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("async_out_valid", 0, FW'(out_valid), FW'(0));
      chk("async_in_ack", 0, FW'(in_ack), FW'(5'b11111));
      for (int p = 0; p < N; p++) send_q[p].delete();
      repeat (2) step();
      rst = 1'b0;
      snap();
      repeat (10) step();
      tot = 0;
      for (int o = 0; o < N; o++) tot += got_n(o);
      chk("no_stale", 0, FW'(tot), FW'(0));

      // randomized traffic at random coordinates
      for (int r = 0; r < 4; r++) begin
         do_reset(2'($urandom_range(3)), 2'($urandom_range(3)));
         gap_pct = 25;
         for (int t = 0; t < 500; t++) begin
            for (int o = 0; o < N; o++) out_ack[o] = ($urandom_range(99) < 80);
            for (int p = 0; p < N; p++) begin
               if (send_q[p].size() == 0 && $urandom_range(3) == 0) begin
                  len = $urandom_range(2, 6);
                  send_q[p].push_back(mk(H, DW'($urandom)));
                  for (int k = 1; k < len - 1; k++) send_q[p].push_back(mk(DT, DW'($urandom)));
                  send_q[p].push_back(mk(TL, DW'($urandom)));
               end
            end
            step();
         end
         out_ack = '1;
         drain(500);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
